// File: rtl/dcache_writeline_arbiter_if.sv
// Bundle of the evict, flush, memory writeline and hazard-check signals around the
// dcache writeline arbiter. slave = arbiter view, master = surrounding logic view.
interface dcache_writeline_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
);
  logic              evict_do;
  logic [ADDR_W-1:0] evict_address;
  logic [LINE_W-1:0] evict_line;
  logic              evict_done;

  logic              flush_do;
  logic [ADDR_W-1:0] flush_address;
  logic [LINE_W-1:0] flush_line;
  logic              flush_done;

  logic              writeline_do;
  logic              writeline_done;
  logic [ADDR_W-1:0] writeline_address;
  logic [LINE_W-1:0] writeline_line;

  logic [ADDR_W-1:0] hazard_address;
  logic              hazard_active;
  logic              busy;

  modport slave (
    input  evict_do, evict_address, evict_line,
    input  flush_do, flush_address, flush_line,
    input  writeline_done, hazard_address,
    output evict_done, flush_done,
    output writeline_do, writeline_address, writeline_line,
    output hazard_active, busy
  );

  modport master (
    output evict_do, evict_address, evict_line,
    output flush_do, flush_address, flush_line,
    output writeline_done, hazard_address,
    input  evict_done, flush_done,
    input  writeline_do, writeline_address, writeline_line,
    input  hazard_active, busy
  );
endinterface

// File: rtl/dcache_writeline_arbiter.sv
// Round-robin arbiter sharing the dcache memory writeline port between dirty-line
// eviction and the WBINVD flush sequencer, with a same-line hazard check for reads.
module dcache_writeline_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
) (
  input  logic                      clk,
  input  logic                      rst_n,
  dcache_writeline_arbiter_if.slave bus
);

  localparam int TAG_W = ADDR_W - 4;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;
  typedef enum logic {GNT_EVICT = 1'b0, GNT_FLUSH = 1'b1} grant_e;

  state_e             state_q, state_d;
  grant_e             grant_q, grant_d;
  grant_e             last_grant_q, last_grant_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [LINE_W-1:0]  line_q, line_d;

  logic [TAG_W-1:0]   evict_tag, flush_tag, hazard_tag;
  logic               unused_low_bits;

  assign evict_tag  = bus.evict_address[ADDR_W-1:4];
  assign flush_tag  = bus.flush_address[ADDR_W-1:4];
  assign hazard_tag = bus.hazard_address[ADDR_W-1:4];
  assign unused_low_bits = ^{bus.evict_address[3:0], bus.flush_address[3:0],
                             bus.hazard_address[3:0]};

  // NOTE: the latched line is a single register, not an array, so it is reset
  // like any other flop; a reset-to-zero output is part of the interface contract.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples its _d value from before the edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= GNT_EVICT;
      last_grant_q <= GNT_FLUSH;
      tag_q        <= '0;
      line_q       <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      tag_q        <= tag_d;
      line_q       <= line_d;
    end
  end

  // NOTE: every variable gets a hold-value default first so no path infers a latch.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    tag_d        = tag_q;
    line_d       = line_q;
    unique case (state_q)
      IDLE: begin
        if (bus.evict_do || bus.flush_do) begin
          if (bus.evict_do && bus.flush_do) begin
            grant_d = (last_grant_q == GNT_FLUSH) ? GNT_EVICT : GNT_FLUSH;
          end else begin
            grant_d = bus.evict_do ? GNT_EVICT : GNT_FLUSH;
          end
          last_grant_d = grant_d;
          tag_d        = (grant_d == GNT_EVICT) ? evict_tag : flush_tag;
          line_d       = (grant_d == GNT_EVICT) ? bus.evict_line : bus.flush_line;
          state_d      = BUSY;
        end
      end
      BUSY: begin
        if (bus.writeline_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Done pulses come straight from writeline_done so the requester sees them in the same cycle.
  always_comb begin
    bus.busy              = (state_q == BUSY);
    bus.writeline_do      = (state_q == BUSY);
    bus.writeline_address = {tag_q, 4'd0};
    bus.writeline_line    = line_q;
    bus.evict_done        = 1'b0;
    bus.flush_done        = 1'b0;
    bus.hazard_active     = 1'b0;
    if (state_q == BUSY) begin
      bus.evict_done    = bus.writeline_done && (grant_q == GNT_EVICT);
      bus.flush_done    = bus.writeline_done && (grant_q == GNT_FLUSH);
      bus.hazard_active = (tag_q == hazard_tag);
    end else begin
      bus.hazard_active = (bus.evict_do && (evict_tag == hazard_tag)) ||
                          (bus.flush_do && (flush_tag == hazard_tag));
    end
  end

endmodule

// File: tb/tb_dcache_writeline_arbiter.sv
// Directed bench for dcache_writeline_arbiter: a per-cycle vector table followed by
// hand-written sequences for arbitration, stability, async reset and protocol errors.
module tb_dcache_writeline_arbiter;

  localparam logic [127:0] EL = {4{32'hE1E1_0001}};
  localparam logic [127:0] FL = {4{32'hF2F2_0002}};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dcache_writeline_arbiter_if bus ();

  dcache_writeline_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        ev_do;
    logic        fl_do;
    logic [31:0] ev_a;
    logic [31:0] fl_a;
    logic        wdone;
    logic [31:0] hz_a;
    logic        x_wdo;
    logic [31:0] x_addr;
    logic [127:0] x_line;
    logic        x_edone;
    logic        x_fdone;
    logic        x_haz;
    logic        x_busy;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic ev_do, input logic fl_do, input logic [31:0] ev_a,
                              input logic [31:0] fl_a, input logic wdone, input logic [31:0] hz_a,
                              input logic x_wdo, input logic [31:0] x_addr, input logic [127:0] x_line,
                              input logic x_edone, input logic x_fdone, input logic x_haz,
                              input logic x_busy);
    vec_t v;
    v.ev_do = ev_do; v.fl_do = fl_do; v.ev_a = ev_a; v.fl_a = fl_a; v.wdone = wdone;
    v.hz_a = hz_a; v.x_wdo = x_wdo; v.x_addr = x_addr; v.x_line = x_line;
    v.x_edone = x_edone; v.x_fdone = x_fdone; v.x_haz = x_haz; v.x_busy = x_busy;
    vq.push_back(v);
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.evict_do = 1'b0; bus.evict_address = '0; bus.evict_line = EL;
    bus.flush_do = 1'b0; bus.flush_address = '0; bus.flush_line = FL;
    bus.writeline_done = 1'b0; bus.hazard_address = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Returns how many negedges passed before writeline_do was seen high.
  task automatic wait_wdo(output int waited);
    waited = 0;
    @(negedge clk);
    while (!bus.writeline_do && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("wdo_timeout", bus.writeline_do, 1'b1);
  endtask

  initial begin
    int w;
    int bad;
    logic [31:0] ra;

    //   ev fl ev_a          fl_a          wd hz_a          | wdo addr          line ed fd hz bs
    add(0, 0, 32'h0,        32'h0,        0, 32'h0,          0, 32'h0,        '0, 0, 0, 0, 0);
    add(0, 0, 32'h0,        32'h0,        1, 32'h0,          0, 32'h0,        '0, 0, 0, 0, 0);
    add(0, 0, 32'h0,        32'h0,        0, 32'h0,          0, 32'h0,        '0, 0, 0, 0, 0);
    add(1, 0, 32'h0001_234C, 32'h0,       0, 32'h0001_2340,  0, 32'h0,        '0, 0, 0, 1, 0);
    add(1, 0, 32'h0001_234C, 32'h0,       0, 32'h0001_2348,  1, 32'h0001_2340, EL, 0, 0, 1, 1);
    add(1, 0, 32'h0001_234C, 32'h0,       0, 32'h0009_9990,  1, 32'h0001_2340, EL, 0, 0, 0, 1);
    add(1, 0, 32'h0001_234C, 32'h0,       0, 32'h0001_2348,  1, 32'h0001_2340, EL, 0, 0, 1, 1);
    add(1, 0, 32'h0001_234C, 32'h0,       0, 32'h0001_2348,  1, 32'h0001_2340, EL, 0, 0, 1, 1);
    add(1, 0, 32'h0001_234C, 32'h0,       1, 32'h0001_2348,  1, 32'h0001_2340, EL, 1, 0, 1, 1);
    add(0, 0, 32'h0001_234C, 32'h0,       0, 32'h0001_2340,  0, 32'h0001_2340, EL, 0, 0, 0, 0);
    add(1, 0, 32'h0000_4A10, 32'h0,       0, 32'h0000_4A1C,  0, 32'h0001_2340, EL, 0, 0, 1, 0);
    add(1, 0, 32'h0000_4A10, 32'h0,       0, 32'h0000_4A1C,  1, 32'h0000_4A10, EL, 0, 0, 1, 1);
    add(1, 0, 32'h0000_4A10, 32'h0,       0, 32'h0000_4A20,  1, 32'h0000_4A10, EL, 0, 0, 0, 1);
    add(1, 0, 32'h0000_4A10, 32'h0,       1, 32'h0000_4A20,  1, 32'h0000_4A10, EL, 1, 0, 0, 1);
    add(0, 0, 32'h0000_4A10, 32'h0,       0, 32'h0000_4A10,  0, 32'h0000_4A10, EL, 0, 0, 0, 0);
    add(0, 1, 32'h0000_8880, 32'h0000_8888, 0, 32'h0000_8884, 0, 32'h0000_4A10, EL, 0, 0, 1, 0);
    add(0, 1, 32'h0000_8880, 32'h0000_8888, 1, 32'h0000_8880, 1, 32'h0000_8880, FL, 0, 1, 1, 1);
    add(0, 0, 32'h0000_8880, 32'h0000_8888, 0, 32'h0000_8880, 0, 32'h0000_8880, FL, 0, 0, 0, 0);

    do_reset();
    foreach (vq[i]) begin
      bus.evict_do = vq[i].ev_do;     bus.evict_address = vq[i].ev_a;
      bus.flush_do = vq[i].fl_do;     bus.flush_address = vq[i].fl_a;
      bus.writeline_done = vq[i].wdone; bus.hazard_address = vq[i].hz_a;
      @(negedge clk);
      check($sformatf("v%0d_wdo", i),   bus.writeline_do,      vq[i].x_wdo);
      check($sformatf("v%0d_addr", i),  bus.writeline_address, vq[i].x_addr);
      check($sformatf("v%0d_line", i),  bus.writeline_line,    vq[i].x_line);
      check($sformatf("v%0d_edone", i), bus.evict_done,        vq[i].x_edone);
      check($sformatf("v%0d_fdone", i), bus.flush_done,        vq[i].x_fdone);
      check($sformatf("v%0d_haz", i),   bus.hazard_active,     vq[i].x_haz);
      check($sformatf("v%0d_busy", i),  bus.busy,              vq[i].x_busy);
      cyc();
    end

    // Both requesters held from reset: grants alternate E,F,E,F with one bubble each.
    do_reset();
    bus.evict_do = 1'b1; bus.evict_address = 32'h0000_1104;
    bus.flush_do = 1'b1; bus.flush_address = 32'h0000_2208;
    for (int k = 0; k < 4; k++) begin
      wait_wdo(w);
      check($sformatf("rr%0d_latency", k), w, 1);
      check($sformatf("rr%0d_addr", k), bus.writeline_address,
            (k % 2 == 0) ? 32'h0000_1100 : 32'h0000_2200);
      check($sformatf("rr%0d_line", k), bus.writeline_line, (k % 2 == 0) ? EL : FL);
      cyc();
      bus.writeline_done = 1'b1;
      @(negedge clk);
      check($sformatf("rr%0d_edone", k), bus.evict_done, (k % 2 == 0) ? 1'b1 : 1'b0);
      check($sformatf("rr%0d_fdone", k), bus.flush_done, (k % 2 == 0) ? 1'b0 : 1'b1);
      cyc();
      bus.writeline_done = 1'b0;
    end

    // Outputs stay on the latched line while inputs churn and memory stalls.
    do_reset();
    bus.evict_do = 1'b1; bus.evict_address = 32'h0000_3000;
    wait_wdo(w);
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      cyc();
      ra = $urandom;
      bus.evict_address = ra;
      bus.evict_line = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      if (bus.writeline_address !== 32'h0000_3000 || bus.writeline_line !== EL ||
          !bus.writeline_do) bad++;
    end
    check("stall_stable_cycles_bad", bad, 0);
    cyc();
    bus.writeline_done = 1'b1;
    @(negedge clk);
    check("stall_edone", bus.evict_done, 1'b1);
    cyc();
    bus.writeline_done = 1'b0; bus.evict_do = 1'b0; bus.evict_line = EL;

    // Async reset in BUSY: evict granted alone so last_grant=EVICT before reset.
    do_reset();
    bus.evict_do = 1'b1; bus.evict_address = 32'h0000_7770;
    wait_wdo(w);
    cyc();
    bus.writeline_done = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("arst_wdo", bus.writeline_do, 1'b0);
    check("arst_edone", bus.evict_done, 1'b0);
    check("arst_busy", bus.busy, 1'b0);
    check("arst_addr", bus.writeline_address, 32'h0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    bus.writeline_done = 1'b0;
    bus.flush_do = 1'b1; bus.flush_address = 32'h0000_9990;
    @(negedge clk);
    check("arst_idle_after", bus.busy, 1'b0);
    @(negedge clk);
    check("arst_tie_addr", bus.writeline_address, 32'h0000_7770);
    check("arst_tie_wdo", bus.writeline_do, 1'b1);

    // Evictor drops its request mid-transfer: transfer still completes from the latch.
    do_reset();
    bus.evict_do = 1'b1; bus.evict_address = 32'h0000_5554;
    wait_wdo(w);
    cyc();
    bus.evict_do = 1'b0; bus.evict_address = 32'h0000_0000;
    @(negedge clk);
    check("drop_still_busy", bus.writeline_do, 1'b1);
    cyc();
    bus.writeline_done = 1'b1;
    @(negedge clk);
    check("drop_edone", bus.evict_done, 1'b1);
    check("drop_addr", bus.writeline_address, 32'h0000_5550);
    cyc();
    bus.writeline_done = 1'b0;
    @(negedge clk);
    check("drop_idle", bus.busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
